// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS HI/LO datapath: operation codes,
// the HI/LO sequencer states and the default operand width.
package mips_pkg;

  localparam int unsigned WWIDTH_DEFAULT = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } state_t;

endpackage

// File: rtl/restoring_div_core.sv
// Unsigned restoring divider: one quotient bit per step, operands are magnitudes.
// load primes the registers; last flags the step that produces the final bit.
module restoring_div_core
  import mips_pkg::*;
#(
  parameter int WWidth = WWIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [WWidth-1:0] dividend,
  input  logic [WWidth-1:0] divisor,
  output logic [WWidth-1:0] quo,
  output logic [WWidth-1:0] rem_out,
  output logic              last
);

  localparam int CW = $clog2(WWidth);

  logic [CW-1:0]     cnt;
  logic [WWidth-1:0] dvs;
  logic [WWidth:0]   rem;
  logic [WWidth+1:0] partial;
  logic [WWidth+1:0] diff;
  logic              keep;

  // Trial subtract is done one bit wider than the remainder so its sign is exact.
  assign partial = {rem, quo[WWidth-1]};
  assign diff    = partial - {2'b00, dvs};
  assign keep    = !diff[WWidth+1];
  assign last    = (cnt == '0);
  assign rem_out = rem[WWidth-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      dvs <= '0;
      rem <= '0;
      quo <= '0;
    end else if (load) begin
      cnt <= CW'(WWidth - 1);
      dvs <= divisor;
      rem <= '0;
      quo <= dividend;
    end else if (step) begin
      rem <= keep ? diff[WWidth:0] : partial[WWidth:0];
      quo <= {quo[WWidth-2:0], keep};
      if (cnt != '0) cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle HI/LO unit: drives the external signed multiplier, corrects MULTU,
// sequences the restoring divider with sign fix-up, and handles MTHI/MTLO.
module hilo_muldiv_unit
  import mips_pkg::*;
#(
  parameter int WWidth = WWIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [WWidth-1:0]   a,
  input  logic [WWidth-1:0]   b,
  output logic [WWidth-1:0]   mul_a,
  output logic [WWidth-1:0]   mul_b,
  input  logic [2*WWidth-1:0] mul_p,
  output logic [WWidth-1:0]   hi,
  output logic [WWidth-1:0]   lo,
  output logic                busy,
  output logic                done,
  output logic                div_zero
);

  state_t            state;
  logic [WWidth-1:0] a_q, mag_a, mag_b, quo, rem, q_fix, r_fix;
  logic              neg_q, neg_r, uns, dz, last, div_load, div_step;
  logic [2*WWidth-1:0] p_fix;

  assign div_load = (state == ST_IDLE) && start && ((op == OP_DIV) || (op == OP_DIVU));
  assign div_step = (state == ST_DIV);
  assign mag_a    = ((op == OP_DIV) && a[WWidth-1]) ? -a : a;
  assign mag_b    = ((op == OP_DIV) && b[WWidth-1]) ? -b : b;
  assign q_fix    = neg_q ? -quo : quo;
  assign r_fix    = neg_r ? -rem : rem;

  // Turn the signed product into the unsigned one by adding back the sign-bit weights.
  always_comb begin
    p_fix = mul_p;
    if (uns) begin
      if (mul_a[WWidth-1]) p_fix = p_fix + {mul_b, {WWidth{1'b0}}};
      if (mul_b[WWidth-1]) p_fix = p_fix + {mul_a, {WWidth{1'b0}}};
    end
  end

  restoring_div_core #(.WWidth(WWidth)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (div_load),
    .step     (div_step),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quo      (quo),
    .rem_out  (rem),
    .last     (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      hi       <= '0;
      lo       <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      a_q      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      uns      <= 1'b0;
      dz       <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                mul_a <= a;
                mul_b <= b;
                uns   <= (op == OP_MULTU);
                busy  <= 1'b1;
                state <= ST_MUL;
              end
              OP_DIV, OP_DIVU: begin
                neg_q <= (op == OP_DIV) && (a[WWidth-1] ^ b[WWidth-1]);
                neg_r <= (op == OP_DIV) && a[WWidth-1];
                dz    <= (b == '0);
                a_q   <= a;
                busy  <= 1'b1;
                state <= ST_DIV;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          {hi, lo} <= p_fix;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= ST_IDLE;
        end
        ST_DIV: begin
          if (last) state <= ST_FIX;
        end
        ST_FIX: begin
          lo       <= dz ? {WWidth{1'b1}} : q_fix;
          hi       <= dz ? a_q : r_fix;
          div_zero <= dz;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
